// File: rtl/d_ff_pkg.sv
// rtl/d_ff_pkg.sv - shared helpers for the elastic d-flip-flop pipeline
// Purpose: width helper for the occupancy counter.
// Contents: cnt_w(depth) returns the bits needed to hold 0..depth.
package d_ff_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// rtl/d_ff_stage.sv - one register stage (data + valid) of the elastic pipeline
// Purpose: holds one WIDTH-bit word and its valid bit; advances when rdy_in is high.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-low reset
//   rdy_in  in  stage may take a new value this edge
//   vld_in  in  incoming word is valid
//   d       in  incoming word
//   vld_q   out registered valid bit
//   q       out registered data word
module d_ff_stage #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_in,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] d,
    output logic             vld_q,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= 1'b0;
            q     <= RST_VAL;
        end else if (rdy_in) begin
            vld_q <= vld_in;
            // A bubble only clears the valid bit; the data register keeps
            // its last word so out_data never goes undefined.
            if (vld_in) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/d_ff_pipe.sv
// rtl/d_ff_pipe.sv - elastic DEPTH-stage register pipeline with valid/ready, flush and occupancy
// Purpose: DEPTH cycles of registered delay with back-pressure and bubble collapse.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-low reset
//   flush      in  synchronous clear of every stage valid bit
//   in_valid   in  producer word present
//   in_ready   out pipe accepts in_data this cycle
//   in_data    in  producer word
//   out_valid  out last stage holds a valid word
//   out_ready  in  consumer accepts out_data this cycle
//   out_data   out last stage data register
//   count      out number of stages holding valid data
module d_ff_pipe
    import d_ff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] stage_rdy;
    logic [DEPTH-1:0] stage_vin;
    logic [WIDTH-1:0] q    [DEPTH];
    logic [WIDTH-1:0] d_in [DEPTH];

    // rdy[i] = !vld[i] | rdy[i+1] unrolls to: some stage at or beyond i is
    // empty, or the consumer is taking the last word. Computing it as a
    // running AND from the output side avoids a self-referencing vector.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        rdy      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & vld[i];
            rdy[i]   = !all_full | out_ready;
        end
    end

    assign in_ready = rdy[0] & !flush;

    // Flush forces every stage to advance with a zero valid bit, which
    // clears all valids while leaving the data registers untouched.
    assign stage_rdy = rdy | {DEPTH{flush}};
    assign stage_vin[0] = in_valid & in_ready;
    assign d_in[0]      = in_data;

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_link
            assign stage_vin[g] = vld[g-1] & !flush;
            assign d_in[g]      = q[g-1];
        end
        for (g = 0; g < DEPTH; g++) begin : g_stage
            d_ff_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .rdy_in (stage_rdy[g]),
                .vld_in (stage_vin[g]),
                .d      (d_in[g]),
                .vld_q  (vld[g]),
                .q      (q[g])
            );
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(vld[i]);
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = q[DEPTH-1];

endmodule
